tof_meas_ctrl: RTL and testbench
================================

TOF_MEAS_CTRL -- requirements
Module: tof_meas_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max clk cycles allowed between samples before abort (legal range 2..1023).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle measurement request; honoured only in IDLE.
REQ-005 SHALL have port n_log2  input  2  sample count = 2^n_log2 (1, 2, 4, 8); captured when start is accepted.
REQ-006 SHALL have port tof_count  input  8  signed TOF sample from the TOF counter.
REQ-007 SHALL have port tof_ready  input  1  one-cycle strobe; tof_count is valid in that cycle.
REQ-008 SHALL have port ack  input  1  consumer acknowledge of the result.
REQ-009 SHALL have port tof_en  output  1  enables the TOF counter input path; high only in RUN.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port avg_valid  output  1  result held valid; high only in DONE.
REQ-012 SHALL have port avg_out  output  8  signed averaged TOF.
REQ-013 SHALL have port timeout  output  1  result aborted by timeout; qualified by avg_valid.

Function
REQ-014 SHALL implement FSM states IDLE, ARM, RUN, DONE.
REQ-015 IDLE->ARM on start; n_log2 latched; start in any other state ignored.
REQ-016 ARM SHALL last exactly one cycle: clears accumulator, sample counter, timer and timeout flag, then ->RUN.
REQ-017 In RUN each tof_ready SHALL add sign-extended tof_count into an 11-bit signed accumulator, increment the sample counter and clear the timer.
REQ-018 RUN->DONE in the cycle after the tof_ready that completes 2^n_log2 samples; avg_valid high from that cycle.
REQ-019 avg_out SHALL equal accumulator arithmetically shifted right by n_log2 (floor toward minus infinity); the 11-bit accumulator never overflows (8 x -128 = -1024).
REQ-020 Timer SHALL count RUN cycles since RUN entry or the last tof_ready; when it reaches TIMEOUT-1 with no tof_ready, ->DONE with timeout=1 and avg_out=0.
REQ-021 tof_ready coinciding with timer expiry SHALL be taken as a sample; no timeout.
REQ-022 tof_ready outside RUN SHALL be ignored.
REQ-023 DONE->IDLE on the cycle after ack is sampled high; avg_out and timeout hold stable until then; ack outside DONE ignored.
REQ-024 start in the same cycle as ack in DONE SHALL be ignored; a new start is honoured only from IDLE.

Reset
REQ-025 reset SHALL override all other inputs and force, next edge: state IDLE, tof_en=0, busy=0, avg_valid=0, avg_out=0, timeout=0, accumulator, sample counter and timer = 0.
REQ-026 reset mid-RUN or mid-DONE SHALL discard the partial/pending result without emitting avg_valid.

Structure
REQ-027 State encodings (IDLE, ARM, RUN, DONE) and the default TIMEOUT SHALL live in the shared constants header with the other estimator constants.
REQ-028 The block SHALL be a single module; no sub-module is required.

Verification
REQ-029 n_log2=2, samples 10, 12, -4, 6 -> accumulator 24, avg_out=6, timeout=0, avg_valid one cycle after the 4th tof_ready.
REQ-030 n_log2=3, eight samples of -128 -> avg_out=-128, no overflow; n_log2=1, samples -3, 0 -> avg_out=-2 (floor).
REQ-031 TIMEOUT=8, n_log2=1, one sample then silence -> DONE with timeout=1, avg_out=0, 7 cycles after that sample.
REQ-032 tof_ready exactly on timer expiry -> counted as a sample, timeout=0; tof_ready strobes in IDLE/DONE -> no effect on the result.
REQ-033 Result held across 5 cycles with ack low, then ack=1 with start=1 -> IDLE, second start needed; reset during RUN -> all outputs 0, no avg_valid.

Source files
------------

// File: rtl/tof_meas_ctrl_pkg.sv
// Shared constants for the TOF estimator: FSM state encodings, datapath
// widths and the default abort timeout.
package tof_meas_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } tof_state_e;

  localparam int unsigned TOF_TIMEOUT_DEF = 255;
  localparam int unsigned TOF_W           = 8;   // signed TOF sample width
  localparam int unsigned ACC_W           = 11;  // 8 x -128 = -1024 fits
  localparam int unsigned CNT_W           = 4;   // up to 8 samples
  localparam int unsigned TMR_W           = 10;  // TIMEOUT <= 1023

  // Number of samples requested by an n_log2 code (1, 2, 4, 8).
  function automatic logic [CNT_W-1:0] n_samples(input logic [1:0] n);
    return CNT_W'(1) << n;
  endfunction

endpackage

// File: rtl/tof_meas_ctrl.sv
// TOF measurement controller: on start, collects 2^n_log2 signed TOF samples,
// averages them with an arithmetic shift (floor) and holds the result until
// acknowledged. A sample gap of TIMEOUT-1 cycles aborts with timeout=1.
//   clk, reset      : clock, synchronous active-high reset
//   start, n_log2   : measurement request (IDLE only) and sample-count code
//   tof_count/ready : signed sample and its one-cycle strobe
//   ack             : consumer acknowledge of the held result
//   tof_en, busy    : counter path enable (RUN), controller busy (not IDLE)
//   avg_valid, avg_out, timeout : held result, valid only in DONE
module tof_meas_ctrl
  import tof_meas_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TOF_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              n_log2,
  input  logic signed [TOF_W-1:0] tof_count,
  input  logic                    tof_ready,
  input  logic                    ack,
  output logic                    tof_en,
  output logic                    busy,
  output logic                    avg_valid,
  output logic signed [TOF_W-1:0] avg_out,
  output logic                    timeout
);

  tof_state_e              state_q, state_d;
  logic [1:0]              n_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TMR_W-1:0]        tmr_q;
  logic signed [TOF_W-1:0] avg_q;
  logic                    to_q;

  logic signed [ACC_W-1:0] acc_sum, acc_shf;
  logic                    last_smp, expire;

  assign acc_sum  = acc_q + {{(ACC_W-TOF_W){tof_count[TOF_W-1]}}, tof_count};
  assign acc_shf  = acc_sum >>> n_q;
  assign last_smp = tof_ready && ((cnt_q + CNT_W'(1)) == n_samples(n_q));
  // tmr_q is the number of RUN cycles elapsed since the reference cycle
  // (RUN entry, or the cycle holding the last sample). Leaving now means
  // DONE is seen TIMEOUT-1 cycles after the reference. A sample in the
  // deciding cycle wins over the abort.
  assign expire   = !tof_ready && (tmr_q >= TMR_W'(TIMEOUT - 2));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_ARM;
      ST_ARM:  state_d = ST_RUN;
      ST_RUN:  if (last_smp || expire) state_d = ST_DONE;
      ST_DONE: if (ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tof_en    = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
    avg_valid = (state_q == ST_DONE);
    avg_out   = avg_q;
    timeout   = to_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      avg_q <= '0;
      to_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) n_q <= n_log2;
        ST_ARM: begin
          acc_q <= '0;
          cnt_q <= '0;
          tmr_q <= '0;
          avg_q <= '0;
          to_q  <= 1'b0;
        end
        ST_RUN: begin
          if (tof_ready) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CNT_W'(1);
            tmr_q <= TMR_W'(1);  // sample cycle is the new reference
            if (last_smp) avg_q <= acc_shf[TOF_W-1:0];
          end else if (expire) begin
            to_q  <= 1'b1;
            avg_q <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tof_meas_ctrl.sv
module tb_tof_meas_ctrl;

  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        n_log2 = 2'd0;
  logic signed [7:0] tof_count = '0;
  logic              tof_ready = 1'b0;
  logic              ack = 1'b0;
  logic              tof_en, busy, avg_valid, timeout;
  logic signed [7:0] avg_out;

  tof_meas_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .n_log2(n_log2),
    .tof_count(tof_count), .tof_ready(tof_ready), .ack(ack),
    .tof_en(tof_en), .busy(busy), .avg_valid(avg_valid),
    .avg_out(avg_out), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 arm, 2 collecting, 3 result held.
  int ph = 0, cyc = 0, deadline = 0, mn = 0, got = 0, sum = 0;
  int r_avg = 0, r_to = 0;
  bit m_clean = 1'b1;  // since reset, before any new measurement
  bit chk_en = 1'b0;

  function automatic int fdiv(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ph = 0; r_avg = 0; r_to = 0; m_clean = 1'b1;
    end else begin
      case (ph)
        0: if (start) begin ph = 1; mn = int'(n_log2); m_clean = 1'b0; end
        1: begin ph = 2; sum = 0; got = 0; deadline = cyc + TO; end
        2: begin
          if (tof_ready) begin
            sum += int'(tof_count);
            got++;
            deadline = cyc + TO - 1;
            if (got == (1 << mn)) begin
              ph = 3; r_avg = fdiv(sum, 1 << mn); r_to = 0;
            end
          end else if (cyc + 1 == deadline) begin
            ph = 3; r_avg = 0; r_to = 1;
          end
        end
        3: if (ack) ph = 0;
        default: ph = 0;
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(ph != 0));
      chk("tof_en", int'(tof_en), int'(ph == 2));
      chk("avg_valid", int'(avg_valid), int'(ph == 3));
      if (ph == 3 || m_clean) begin
        chk("avg_out", int'(avg_out), r_avg);
        chk("timeout", int'(timeout), r_to);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_meas(input int n);
    start = 1'b1; n_log2 = 2'(n);
    tick;
    start = 1'b0;
    tick;
    chk("run_entry", int'(tof_en), 1);
  endtask

  task automatic send(input int v);
    tof_ready = 1'b1; tof_count = 8'(v);
    tick;
    tof_ready = 1'b0; tof_count = '0;
  endtask

  task automatic expect_done(input string name, input int a, input int t);
    chk({name, "_valid"}, int'(avg_valid), 1);
    chk({name, "_avg"}, int'(avg_out), a);
    chk({name, "_to"}, int'(timeout), t);
    chk({name, "_model"}, r_avg, a);
  endtask

  task automatic do_ack;
    ack = 1'b1; tick; ack = 1'b0;
    chk("ack_idle", int'(busy), 0);
  endtask

  initial begin
    int cnt;
    tick; chk_en = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_avg", int'(avg_out), 0);

    // strobe in IDLE is ignored
    send(100);

    // 10 + 12 - 4 + 6 = 24, /4 = 6, valid the cycle after the 4th sample
    start_meas(2);
    send(10); tick; send(12); send(-4); tick; tick; send(6);
    expect_done("avg4", 6, 0);
    do_ack;

    // eight samples of -128: -1024 >>> 3 = -128
    start_meas(3);
    for (int i = 0; i < 8; i++) send(-128);
    expect_done("min8", -128, 0);
    do_ack;

    // -3 + 0 = -3, floor(-3/2) = -2
    start_meas(1);
    send(-3); send(0);
    expect_done("floor", -2, 0);
    do_ack;

    // one sample then silence: DONE seen 7 cycles after the sample cycle
    start_meas(1);
    send(5);
    cnt = 0;
    while (!avg_valid && cnt < 50) begin tick; cnt++; end
    chk("to_latency", cnt, 6);
    expect_done("tmo", 0, 1);
    do_ack;

    // second sample lands in the expiry cycle: taken, no timeout, (1+3)/2
    start_meas(1);
    send(1);
    repeat (5) tick;
    send(3);
    expect_done("edge", 2, 0);
    // hold 5 cycles, strobe during DONE ignored
    repeat (2) tick;
    send(77);
    repeat (2) tick;
    expect_done("hold", 2, 0);
    // ack with start: start ignored
    ack = 1'b1; start = 1'b1; tick; ack = 1'b0; start = 1'b0;
    chk("ackstart_idle", int'(busy), 0);
    tick;
    chk("ackstart_stay", int'(busy), 0);

    // reset during RUN discards the partial result
    start_meas(2);
    send(20);
    reset = 1'b1; tick; reset = 1'b0;
    chk("rrun_busy", int'(busy), 0);
    chk("rrun_en", int'(tof_en), 0);
    chk("rrun_valid", int'(avg_valid), 0);
    chk("rrun_avg", int'(avg_out), 0);
    chk("rrun_to", int'(timeout), 0);
    repeat (12) tick;
    chk("rrun_novalid", int'(avg_valid), 0);

    // fresh measurement after reset unaffected by discarded sample
    start_meas(0);
    send(-7);
    expect_done("post", -7, 0);
    do_ack;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
